// File: rtl/data_mem_resp_pkg.sv
// Shared types and defaults for the data memory responder.
package data_mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LATENCY_DEF    = 4;
  localparam int DEPTH_LOG2_DEF = 8;

endpackage

// File: rtl/data_mem_array.sv
// Single-port 16-bit word store: synchronous write, combinational read.
// Contents are deliberately never reset.
module data_mem_array #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [15:0]           wdata,
  output logic [15:0]           rdata
);

  logic [15:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_resp.sv
// Fixed-latency memory responder (IDLE/BUSY/RESP); define DATA_MEM_HIT_BUF_EN
// to add a one-entry read hit buffer that answers matching reads in one cycle.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int LATENCY    = LATENCY_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        err,
  output logic        CacheHit
);

  state_t                state, state_nxt;
  logic [3:0]            cnt;
  logic                  op_wr;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [15:0]           wdat_q;
  logic [15:0]           resp_dat;
  logic                  resp_err;
  logic                  resp_hit;
  logic [15:0]           mem_rdat;
  logic                  mem_we;

  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  req_ok;
  logic                  req_bad;
  logic                  hit_req;
  logic [15:0]           hit_dat;
  logic                  done_busy;
  logic                  unused_addr;

  // Upper address bits alias onto the same words.
  assign req_idx     = Addr[DEPTH_LOG2:1];
  assign unused_addr = ^Addr[15:DEPTH_LOG2+1];

  assign req_ok    = (Rd ^ Wr) & ~Addr[0];
  assign req_bad   = (Rd & Wr) | (Addr[0] & (Rd | Wr));
  assign done_busy = (state == BUSY) && (cnt == 4'd1);
  assign mem_we    = done_busy & op_wr;

`ifdef DATA_MEM_HIT_BUF_EN
  logic                  hb_vld;
  logic [DEPTH_LOG2-1:0] hb_idx;
  logic [15:0]           hb_dat;

  assign hit_req = req_ok & Rd & hb_vld & (hb_idx == req_idx);
  assign hit_dat = hb_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_vld <= 1'b0;
      hb_idx <= '0;
      hb_dat <= '0;
    end else if (done_busy) begin
      if (!op_wr) begin
        hb_vld <= 1'b1;
        hb_idx <= idx_q;
        hb_dat <= mem_rdat;
      end else if (hb_vld && (hb_idx == idx_q)) begin
        hb_dat <= wdat_q;
      end
    end
  end
`else
  assign hit_req = 1'b0;
  assign hit_dat = '0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_bad || hit_req) state_nxt = RESP;
        else if (req_ok)        state_nxt = BUSY;
      end
      BUSY:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_wr    <= 1'b0;
      idx_q    <= '0;
      wdat_q   <= '0;
      resp_dat <= '0;
      resp_err <= 1'b0;
      resp_hit <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_bad) begin
            resp_err <= 1'b1;
            resp_hit <= 1'b0;
            resp_dat <= '0;
          end else if (hit_req) begin
            resp_err <= 1'b0;
            resp_hit <= 1'b1;
            resp_dat <= hit_dat;
          end else if (req_ok) begin
            op_wr  <= Wr;
            idx_q  <= req_idx;
            wdat_q <= DataIn;
            cnt    <= 4'(LATENCY - 1);
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            resp_err <= 1'b0;
            resp_hit <= 1'b0;
            resp_dat <= op_wr ? 16'h0000 : mem_rdat;
          end
        end
        default: ;
      endcase
    end
  end

  data_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (idx_q),
    .wdata (wdat_q),
    .rdata (mem_rdat)
  );

  assign Done     = (state == RESP);
  assign Stall    = (state == BUSY);
  assign err      = Done & resp_err;
  assign CacheHit = Done & resp_hit;
  assign DataOut  = Done ? resp_dat : 16'h0000;

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter LATENCY, default 4, cycles from request acceptance to Done; legal range 2..15.
REQ-002 Parameter DEPTH_LOG2, default 8, log2 of the number of 16-bit words in the backing store.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port Addr  input  16  byte address of the request.
REQ-006 Port DataIn  input  16  write data.
REQ-007 Port Rd  input  1  read request.
REQ-008 Port Wr  input  1  write request.
REQ-009 Port DataOut  output  16  read data; valid only while Done=1.
REQ-010 Port Done  output  1  one-cycle completion pulse.
REQ-011 Port Stall  output  1  responder busy; new requests ignored.
REQ-012 Port err  output  1  one-cycle error pulse, coincident with Done.
REQ-013 Port CacheHit  output  1  completion served from the hit buffer; valid while Done=1.

Function
REQ-014 FSM states IDLE, BUSY, RESP; Rd/Wr sampled only in IDLE.
REQ-015 IDLE, Rd xor Wr, Addr[0]=0: latch Addr, DataIn, op; load counter with LATENCY-1; go BUSY.
REQ-016 IDLE, Rd and Wr both 1, or Addr[0]=1 with Rd or Wr: no array access; go RESP with err=1, DataOut=0.
REQ-017 BUSY: Stall=1; counter decrements each cycle; at counter=1 go RESP.
REQ-018 Request accepted at edge T produces Done=1 in the cycle after edge T+LATENCY-1 (exactly LATENCY cycles after acceptance cycle).
REQ-019 RESP: Done=1 for exactly one cycle, Stall=0; next state IDLE; Rd/Wr in RESP are ignored.
REQ-020 Word index = Addr[DEPTH_LOG2:1]; upper address bits ignored (aliasing wrap).
REQ-021 Write commits DataIn to the array on the BUSY->RESP edge; DataOut=0 for write completions.
REQ-022 Read fetches array word on the BUSY->RESP edge; a read after a completed write to the same word returns the new data.
REQ-023 Stall=0 in IDLE and RESP; Done, err, CacheHit=0 outside RESP.

Reset
REQ-024 rst asserted at any time forces state IDLE, counter 0, Done=0, Stall=0, err=0, CacheHit=0, DataOut=0, hit buffer invalid; an in-flight write is discarded.
REQ-025 Array contents are not cleared by reset.

Configuration
REQ-026 Macro DATA_MEM_HIT_BUF_EN compiles in a one-entry read hit buffer (valid, word index, data).
REQ-027 With macro: aligned IDLE read matching a valid entry goes directly to RESP; Done one cycle after acceptance, CacheHit=1, DataOut=buffer data.
REQ-028 With macro: every read completion through BUSY loads the buffer and sets valid; a write completion to the matching index updates buffer data.
REQ-029 Without macro: CacheHit tied 0; every legal request takes LATENCY cycles.

Structure
REQ-030 Shared package holds the FSM state encoding (2-bit IDLE=0, BUSY=1, RESP=2) and LATENCY/DEPTH_LOG2 defaults.
REQ-031 One sub-module, data_mem_array: single-port synchronous-write, DEPTH_LOG2-addressed 16-bit storage.

Verification
REQ-032 Write Addr=0x0010 DataIn=0xBEEF, then read 0x0010 -> Done 4 cycles after each acceptance, read DataOut=0xBEEF, err=0.
REQ-033 Read Addr=0x0003 -> RESP after 1 cycle, Done=1, err=1, DataOut=0, array unchanged.
REQ-034 Rd=Wr=1 Addr=0x0020 -> err=1 with Done; Addr 0x0020 retains prior value.
REQ-035 Rd held high through BUSY and RESP -> exactly one Done per acceptance; Stall=1 for 3 cycles per access at LATENCY=4.
REQ-036 rst pulsed mid-BUSY of write 0x0040=0x1234 -> no Done; subsequent read 0x0040 returns pre-write value.
REQ-037 With DATA_MEM_HIT_BUF_EN: read 0x0010 twice -> second Done 1 cycle after acceptance, CacheHit=1, DataOut=0xBEEF; write 0x0010=0x5555 then read -> CacheHit=1, DataOut=0x5555.
